// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with two-flop rx synchroniser, mid-bit sampling,
// ready/valid byte output and single-cycle framing/overrun pulses.
module uart_receiver #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);
    localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_receiver: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    sync_q, sync_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          rx_s, tick;

    assign rx_s = sync_q[1];
    assign tick = cnt_q == '0;

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !ready;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = HALF;
            end
            START: if (tick) begin
                state_d = rx_s ? IDLE : DATA;
                cnt_d   = FULL;
                idx_d   = 3'd0;
            end
            DATA: if (tick) begin
                shift_d = {rx_s, shift_q[7:1]};
                cnt_d   = FULL;
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_d = rx_s ? IDLE : BREAK;
                fe_d    = !rx_s;
                // A byte still held and not being accepted this cycle wins over the new one.
                if (rx_s && (!valid_q || ready)) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end
                ov_d = rx_s && valid_q && !ready;
            end
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            sync_q  <= 2'b11;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver at DIV=16 (1600 Hz clock, 100 baud).
module tb_uart_receiver;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;

    uart_receiver #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data(data), .valid(valid),
        .ready(ready), .framing_error(framing_error), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         rise_n = 0;
    int         rise_cyc [64];
    logic [7:0] rise_dat [64];
    int         fe_n = 0;
    int         ov_n = 0;
    int         both_n = 0;
    int         ov_last = -1;
    logic       valid_prev = 1'b0;

    always @(negedge clock) begin
        if (valid && !valid_prev && rise_n < 64) begin
            rise_cyc[rise_n] = cyc;
            rise_dat[rise_n] = data;
            rise_n++;
        end
        valid_prev = valid;
        if (framing_error) fe_n++;
        if (overrun) begin
            ov_n++;
            ov_last = cyc;
        end
        if (framing_error && overrun) both_n++;
    end

    int checks = 0;
    int errors = 0;
    int e0_last = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send(logic [7:0] b, logic stop);
        e0_last = cyc + 1;
        rx = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clock);
        end
        rx = stop;
        repeat (16) @(negedge clock);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        chk("accept_clears_valid", {31'd0, valid}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, o0, t, e0s;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 8'h3C, 1};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};

        repeat (3) @(negedge clock);
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_fe", {31'd0, framing_error}, 32'd0);
        chk("reset_ov", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        idle(5);

        r0 = rise_n; f0 = fe_n;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        idle(200);
        chk("glitch_no_valid", rise_n - r0, 0);
        chk("glitch_no_fe", fe_n - f0, 0);

        for (int v = 0; v < 6; v++) begin
            r0 = rise_n; f0 = fe_n; o0 = ov_n;
            send(vecs[v].b, vecs[v].stop);
            idle(20);
            chk($sformatf("vec%0d_valid", v), {31'd0, valid}, {31'd0, vecs[v].exp_valid});
            chk($sformatf("vec%0d_data", v), {24'd0, data}, {24'd0, vecs[v].exp_data});
            chk($sformatf("vec%0d_fe", v), fe_n - f0, vecs[v].exp_fe);
            chk($sformatf("vec%0d_ov", v), ov_n - o0, 0);
            chk($sformatf("vec%0d_rises", v), rise_n - r0, {31'd0, vecs[v].exp_valid});
            if (vecs[v].exp_valid && rise_n > r0)
                chk($sformatf("vec%0d_rise_cycle", v), rise_cyc[r0], e0_last + 154);
            accept();
        end

        r0 = rise_n; f0 = fe_n;
        send(8'h55, 1'b0);
        repeat (40) @(negedge clock);
        chk("break_fe_once", fe_n - f0, 1);
        chk("break_no_valid", {31'd0, valid}, 32'd0);
        idle(200);
        chk("break_no_new_frame", rise_n - r0, 0);
        chk("break_fe_still_once", fe_n - f0, 1);
        send(8'h81, 1'b1);
        idle(20);
        chk("after_break_valid", {31'd0, valid}, 32'd1);
        chk("after_break_data", {24'd0, data}, 32'h81);
        accept();

        r0 = rise_n; f0 = fe_n; o0 = ov_n;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        idle(20);
        chk("overrun_data_kept", {24'd0, data}, 32'h11);
        chk("overrun_valid", {31'd0, valid}, 32'd1);
        chk("overrun_pulses", ov_n - o0, 1);
        chk("overrun_cycle", ov_last, e0_last + 154);
        chk("overrun_no_fe", fe_n - f0, 0);
        chk("overrun_rises", rise_n - r0, 1);
        accept();

        r0 = rise_n; o0 = ov_n;
        t = cyc + 1 + 160 + 153;
        fork
            begin
                send(8'h11, 1'b1);
                send(8'h22, 1'b1);
            end
            begin
                while (cyc != t) @(negedge clock);
                ready = 1'b1;
                @(negedge clock);
                ready = 1'b0;
            end
        join
        idle(20);
        chk("simul_accept_data", {24'd0, data}, 32'h22);
        chk("simul_accept_valid", {31'd0, valid}, 32'd1);
        chk("simul_accept_no_ov", ov_n - o0, 0);
        chk("simul_accept_rises", rise_n - r0, 1);
        accept();

        ready = 1'b1;
        r0 = rise_n;
        e0s = cyc + 1;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h7E, 1'b1);
        idle(20);
        ready = 1'b0;
        chk("stream_rises", rise_n - r0, 3);
        if (rise_n - r0 == 3) begin
            chk("stream_first_cycle", rise_cyc[r0], e0s + 154);
            chk("stream_gap1", rise_cyc[r0+1] - rise_cyc[r0], 160);
            chk("stream_gap2", rise_cyc[r0+2] - rise_cyc[r0+1], 160);
            chk("stream_d0", {24'd0, rise_dat[r0]}, 32'h00);
            chk("stream_d1", {24'd0, rise_dat[r0+1]}, 32'hFF);
            chk("stream_d2", {24'd0, rise_dat[r0+2]}, 32'h7E);
        end
        chk("stream_valid_cleared", {31'd0, valid}, 32'd0);

        send(8'hC3, 1'b1);
        idle(5);
        chk("pre_reset_valid", {31'd0, valid}, 32'd1);
        fork
            send(8'hF0, 1'b1);
            begin
                repeat (16 * 5 + 8) @(negedge clock);
                #2 reset = 1'b1;
                #1;
                chk("async_reset_data", {24'd0, data}, 32'h00);
                chk("async_reset_valid", {31'd0, valid}, 32'd0);
                chk("async_reset_fe", {31'd0, framing_error}, 32'd0);
                chk("async_reset_ov", {31'd0, overrun}, 32'd0);
                @(negedge clock);
                reset = 1'b0;
            end
        join
        idle(20);
        r0 = rise_n;
        send(8'h5A, 1'b1);
        idle(20);
        chk("post_reset_valid", {31'd0, valid}, 32'd1);
        chk("post_reset_data", {24'd0, data}, 32'h5A);
        chk("post_reset_rises", rise_n - r0, 1);
        accept();

        chk("never_fe_and_ov", both_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
